// File: rtl/bp_be_fe_cmd_gen_if.sv
// Backend-to-frontend command bundle: execute-stage resolutions in, redirect/attaboy commands out.
// slave is the command generator, master is the execute stage / frontend pair that drives and consumes it.
interface bp_be_fe_cmd_gen_if #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 64,
  parameter int drop_cnt_width_p            = 8
);
  logic                                   res_v_i;
  logic                                   res_epoch_i;
  logic [vaddr_width_p-1:0]               res_pc_i;
  logic [vaddr_width_p-1:0]               res_tgt_i;
  logic [vaddr_width_p-1:0]               res_pred_npc_i;
  logic                                   res_taken_i;
  logic                                   res_is_br_i;
  logic                                   res_is_jmp_i;
  logic                                   res_nonbr_i;
  logic [branch_metadata_fwd_width_p-1:0] res_metadata_i;
  logic                                   ext_redirect_v_i;
  logic [vaddr_width_p-1:0]               ext_redirect_pc_i;

  logic                                   redirect_v_o;
  logic [vaddr_width_p-1:0]               redirect_pc_o;
  logic                                   redirect_br_v_o;
  logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o;
  logic                                   redirect_br_taken_o;
  logic                                   redirect_br_ntaken_o;
  logic                                   redirect_br_nonbr_o;

  logic                                   attaboy_v_o;
  logic [vaddr_width_p-1:0]               attaboy_pc_o;
  logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o;
  logic                                   attaboy_taken_o;
  logic                                   attaboy_ntaken_o;
  logic                                   attaboy_yumi_i;

  logic                                   epoch_o;
  logic [drop_cnt_width_p-1:0]            drop_cnt_o;

  modport slave (
    input  res_v_i, res_epoch_i, res_pc_i, res_tgt_i, res_pred_npc_i, res_taken_i,
           res_is_br_i, res_is_jmp_i, res_nonbr_i, res_metadata_i,
           ext_redirect_v_i, ext_redirect_pc_i, attaboy_yumi_i,
    output redirect_v_o, redirect_pc_o, redirect_br_v_o, redirect_br_metadata_fwd_o,
           redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o,
           attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o, attaboy_taken_o,
           attaboy_ntaken_o, epoch_o, drop_cnt_o
  );

  modport master (
    output res_v_i, res_epoch_i, res_pc_i, res_tgt_i, res_pred_npc_i, res_taken_i,
           res_is_br_i, res_is_jmp_i, res_nonbr_i, res_metadata_i,
           ext_redirect_v_i, ext_redirect_pc_i, attaboy_yumi_i,
    input  redirect_v_o, redirect_pc_o, redirect_br_v_o, redirect_br_metadata_fwd_o,
           redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o,
           attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o, attaboy_taken_o,
           attaboy_ntaken_o, epoch_o, drop_cnt_o
  );
endinterface

// File: rtl/bp_be_fe_cmd_gen.sv
// Frontend redirect/attaboy generator: redirect registered 1 cycle after resolution, attaboy visible 1 cycle after enqueue.
// Redirects have no backpressure; attaboys queue in a FIFO drained by valid/yumi and are dropped (and counted) when full.
module bp_be_fe_cmd_gen #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 64,
  parameter int attaboy_els_p               = 4,
  parameter int drop_cnt_width_p            = 8
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  bp_be_fe_cmd_gen_if.slave   io
);

  localparam int ptr_w = $clog2(attaboy_els_p);
  localparam int cnt_w = $clog2(attaboy_els_p + 1);

  typedef struct packed {
    logic [vaddr_width_p-1:0]               pc;
    logic [branch_metadata_fwd_width_p-1:0] md;
    logic                                   taken;
    logic                                   ntaken;
  } attaboy_t;

  logic                          epoch_r;
  logic                          is_nonbr, is_jmp, is_br;
  logic                          live, taken, ntaken, mispredict, enq;
  logic [vaddr_width_p-1:0]      pc_plus4, actual_npc;

  logic                                   redir_v_r;
  logic [vaddr_width_p-1:0]               redir_pc_r;
  logic                                   redir_br_v_r;
  logic [branch_metadata_fwd_width_p-1:0] redir_md_r;
  logic                                   redir_taken_r, redir_ntaken_r, redir_nonbr_r;

  attaboy_t                      mem [attaboy_els_p];
  attaboy_t                      wr_entry, head;
  logic [ptr_w-1:0]              wr_ptr, rd_ptr;
  logic [cnt_w-1:0]              cnt;
  logic [drop_cnt_width_p-1:0]   drop_cnt_r;
  logic                          empty, full, deq, accept, drop;

  // Kind flags are made one-hot so taken/ntaken/nonbr can never overlap.
  always_comb begin
    is_nonbr   = io.res_nonbr_i;
    is_jmp     = io.res_is_jmp_i & ~io.res_nonbr_i;
    is_br      = io.res_is_br_i & ~io.res_is_jmp_i & ~io.res_nonbr_i;
    live       = io.res_v_i & (io.res_epoch_i == epoch_r) & (is_br | is_jmp | is_nonbr);
    pc_plus4   = io.res_pc_i + vaddr_width_p'(4);
    actual_npc = pc_plus4;
    if (is_jmp | (is_br & io.res_taken_i)) actual_npc = io.res_tgt_i;
    taken      = (is_br & io.res_taken_i) | is_jmp;
    ntaken     = is_br & ~io.res_taken_i;
    mispredict = live & (is_nonbr | (actual_npc != io.res_pred_npc_i));
    enq        = live & ~mispredict & ~io.ext_redirect_v_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      epoch_r        <= 1'b0;
      redir_v_r      <= 1'b0;
      redir_pc_r     <= '0;
      redir_br_v_r   <= 1'b0;
      redir_md_r     <= '0;
      redir_taken_r  <= 1'b0;
      redir_ntaken_r <= 1'b0;
      redir_nonbr_r  <= 1'b0;
    end else begin
      if (io.ext_redirect_v_i) begin
        redir_v_r      <= 1'b1;
        redir_pc_r     <= io.ext_redirect_pc_i;
        redir_br_v_r   <= 1'b0;
        redir_md_r     <= '0;
        redir_taken_r  <= 1'b0;
        redir_ntaken_r <= 1'b0;
        redir_nonbr_r  <= 1'b0;
      end else if (mispredict) begin
        redir_v_r      <= 1'b1;
        redir_pc_r     <= actual_npc;
        redir_br_v_r   <= 1'b1;
        redir_md_r     <= io.res_metadata_i;
        redir_taken_r  <= taken;
        redir_ntaken_r <= ntaken;
        redir_nonbr_r  <= is_nonbr;
      end else begin
        redir_v_r      <= 1'b0;
        redir_pc_r     <= '0;
        redir_br_v_r   <= 1'b0;
        redir_md_r     <= '0;
        redir_taken_r  <= 1'b0;
        redir_ntaken_r <= 1'b0;
        redir_nonbr_r  <= 1'b0;
      end
      if (io.ext_redirect_v_i | mispredict) epoch_r <= ~epoch_r;
    end
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  always_comb begin
    empty    = (cnt == '0);
    full     = (cnt == cnt_w'(attaboy_els_p));
    deq      = io.attaboy_yumi_i & ~empty;
    accept   = enq & (~full | deq);
    drop     = enq & full & ~deq;
    wr_entry = '{pc: actual_npc, md: io.res_metadata_i, taken: taken, ntaken: ntaken};
    head     = mem[rd_ptr];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + ptr_w'(1);
      if (deq)    rd_ptr <= rd_ptr + ptr_w'(1);
      cnt <= cnt + cnt_w'(accept) - cnt_w'(deq);
      if (drop && !(&drop_cnt_r)) drop_cnt_r <= drop_cnt_r + drop_cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && io.attaboy_yumi_i) assert (!empty);
  end

  assign io.redirect_v_o               = redir_v_r;
  assign io.redirect_pc_o              = redir_pc_r;
  assign io.redirect_br_v_o            = redir_br_v_r;
  assign io.redirect_br_metadata_fwd_o = redir_md_r;
  assign io.redirect_br_taken_o        = redir_taken_r;
  assign io.redirect_br_ntaken_o       = redir_ntaken_r;
  assign io.redirect_br_nonbr_o        = redir_nonbr_r;

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign io.attaboy_v_o                = ~empty;
  assign io.attaboy_pc_o               = empty ? '0 : head.pc;
  assign io.attaboy_br_metadata_fwd_o  = empty ? '0 : head.md;
  assign io.attaboy_taken_o            = ~empty & head.taken;
  assign io.attaboy_ntaken_o           = ~empty & head.ntaken;

  assign io.epoch_o                    = epoch_r;
  assign io.drop_cnt_o                 = drop_cnt_r;

endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// Directed bench for bp_be_fe_cmd_gen: redirect checks against constants, attaboys against a scoreboard queue.
module tb_bp_be_fe_cmd_gen;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bp_be_fe_cmd_gen_if #(.vaddr_width_p(39), .branch_metadata_fwd_width_p(64), .drop_cnt_width_p(8)) io ();

  bp_be_fe_cmd_gen #(
    .vaddr_width_p(39), .branch_metadata_fwd_width_p(64), .attaboy_els_p(4), .drop_cnt_width_p(8)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .io(io.slave)
  );

  typedef struct {
    logic [38:0] pc;
    logic [63:0] md;
    logic        t;
    logic        nt;
  } exp_t;

  exp_t        sb [$];
  int          nvec = 0;
  int          nerr = 0;
  int          exp_drop = 0;
  logic [38:0] pc_v, tgt_v;
  logic [63:0] md_v;
  exp_t        e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    io.res_v_i = 0; io.res_epoch_i = 0; io.res_pc_i = '0; io.res_tgt_i = '0;
    io.res_pred_npc_i = '0; io.res_taken_i = 0; io.res_is_br_i = 0; io.res_is_jmp_i = 0;
    io.res_nonbr_i = 0; io.res_metadata_i = '0; io.ext_redirect_v_i = 0;
    io.ext_redirect_pc_i = '0; io.attaboy_yumi_i = 0;
  endtask

  task automatic res(input logic ep, input logic [38:0] pc, input logic [38:0] tgt,
                     input logic [38:0] pred, input logic tk, input logic br,
                     input logic jmp, input logic nb, input logic [63:0] md);
    io.res_v_i = 1; io.res_epoch_i = ep; io.res_pc_i = pc; io.res_tgt_i = tgt;
    io.res_pred_npc_i = pred; io.res_taken_i = tk; io.res_is_br_i = br;
    io.res_is_jmp_i = jmp; io.res_nonbr_i = nb; io.res_metadata_i = md;
  endtask

  task automatic push(input logic [38:0] pc, input logic [63:0] md, input logic t, input logic nt);
    exp_t x;
    x.pc = pc; x.md = md; x.t = t; x.nt = nt;
    if (sb.size() < 4) sb.push_back(x);
    else exp_drop++;
  endtask

  task automatic chk_head(input string tag, input exp_t x);
    chk({tag, "_v"},  64'(io.attaboy_v_o), 64'd1);
    chk({tag, "_pc"}, 64'(io.attaboy_pc_o), 64'(x.pc));
    chk({tag, "_md"}, io.attaboy_br_metadata_fwd_o, x.md);
    chk({tag, "_t"},  64'(io.attaboy_taken_o), 64'(x.t));
    chk({tag, "_nt"}, 64'(io.attaboy_ntaken_o), 64'(x.nt));
  endtask

  task automatic drain_one(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(io.attaboy_v_o), 64'd0);
    end else begin
      x = sb.pop_front();
      chk_head(tag, x);
      io.attaboy_yumi_i = io.attaboy_v_o;
      tick();
      io.attaboy_yumi_i = 0;
    end
  endtask

  task automatic chk_redir(input string tag, input logic [38:0] pc, input logic brv,
                           input logic t, input logic nt, input logic nb);
    chk({tag, "_v"},   64'(io.redirect_v_o), 64'd1);
    chk({tag, "_pc"},  64'(io.redirect_pc_o), 64'(pc));
    chk({tag, "_brv"}, 64'(io.redirect_br_v_o), 64'(brv));
    chk({tag, "_t"},   64'(io.redirect_br_taken_o), 64'(t));
    chk({tag, "_nt"},  64'(io.redirect_br_ntaken_o), 64'(nt));
    chk({tag, "_nb"},  64'(io.redirect_br_nonbr_o), 64'(nb));
  endtask

  initial begin
    idle();
    reset_n_i = 0;
    repeat (3) tick();
    chk("rst_redir_v", 64'(io.redirect_v_o), 64'd0);
    chk("rst_att_v",   64'(io.attaboy_v_o), 64'd0);
    chk("rst_epoch",   64'(io.epoch_o), 64'd0);
    chk("rst_drop",    64'(io.drop_cnt_o), 64'd0);
    reset_n_i = 1;
    tick();

    // correct taken branch
    res(0, 39'h1000, 39'h1040, 39'h1040, 1, 1, 0, 0, 64'hA1);
    push(39'h1040, 64'hA1, 1, 0);
    tick(); idle();
    chk("t1_redir_v", 64'(io.redirect_v_o), 64'd0);
    chk("t1_epoch",   64'(io.epoch_o), 64'd0);
    drain_one("t1_att");
    chk("t1_att_empty", 64'(io.attaboy_v_o), 64'd0);

    // mispredicted not-taken branch
    res(0, 39'h2000, 39'h2080, 39'h2080, 0, 1, 0, 0, 64'hA2);
    tick(); idle();
    chk_redir("t2_redir", 39'h2004, 1, 0, 1, 0);
    chk("t2_md",    io.redirect_br_metadata_fwd_o, 64'hA2);
    chk("t2_epoch", 64'(io.epoch_o), 64'd1);
    chk("t2_att_v", 64'(io.attaboy_v_o), 64'd0);
    tick();
    chk("t2_pulse_end", 64'(io.redirect_v_o), 64'd0);

    // stale-epoch resolutions are ignored
    res(0, 39'h2100, 39'h2200, 39'h2104, 1, 1, 0, 0, 64'hA3);
    tick(); idle();
    res(0, 39'h2200, 39'h2300, 39'h2300, 0, 0, 1, 0, 64'hA4);
    tick(); idle();
    tick();
    chk("t3_stale_redir", 64'(io.redirect_v_o), 64'd0);
    chk("t3_stale_att",   64'(io.attaboy_v_o), 64'd0);
    chk("t3_stale_epoch", 64'(io.epoch_o), 64'd1);

    // false BTB hit
    res(1, 39'h3000, 39'h3100, 39'h3100, 0, 0, 0, 1, 64'hA5);
    tick(); idle();
    chk_redir("t4_redir", 39'h3004, 1, 0, 0, 1);
    chk("t4_epoch", 64'(io.epoch_o), 64'd0);

    // ext redirect beats mispredicting branch
    res(0, 39'h4000, 39'h4040, 39'h4004, 1, 1, 0, 0, 64'hA6);
    io.ext_redirect_v_i = 1; io.ext_redirect_pc_i = 39'h8000_0000;
    tick(); idle();
    chk_redir("t5_ext", 39'h8000_0000, 0, 0, 0, 0);
    chk("t5_epoch", 64'(io.epoch_o), 64'd1);
    tick();
    chk("t5_pulse_end", 64'(io.redirect_v_o), 64'd0);
    chk("t5_epoch_once", 64'(io.epoch_o), 64'd1);

    // ext redirect suppresses a same-cycle correct attaboy
    res(1, 39'h4100, 39'h4200, 39'h4200, 0, 0, 1, 0, 64'hA7);
    io.ext_redirect_v_i = 1; io.ext_redirect_pc_i = 39'h8000_0100;
    tick(); idle();
    chk_redir("t6_ext", 39'h8000_0100, 0, 0, 0, 0);
    chk("t6_epoch", 64'(io.epoch_o), 64'd0);
    tick();
    chk("t6_att_v", 64'(io.attaboy_v_o), 64'd0);

    // six correct resolutions into a depth-4 FIFO
    for (int i = 0; i < 6; i++) begin
      pc_v  = 39'h5000 + 39'(i) * 39'h100;
      tgt_v = pc_v + 39'h40;
      md_v  = 64'hB0 + 64'(i);
      case (i % 3)
        0: begin res(0, pc_v, tgt_v, tgt_v, 1, 1, 0, 0, md_v); push(tgt_v, md_v, 1, 0); end
        1: begin res(0, pc_v, tgt_v, pc_v + 39'h4, 0, 1, 0, 0, md_v); push(pc_v + 39'h4, md_v, 0, 1); end
        default: begin res(0, pc_v, tgt_v, tgt_v, 0, 0, 1, 0, md_v); push(tgt_v, md_v, 1, 0); end
      endcase
      tick();
    end
    idle();
    chk("t7_drop",   64'(io.drop_cnt_o), 64'(exp_drop));
    chk("t7_redir",  64'(io.redirect_v_o), 64'd0);

    // full FIFO: enqueue and dequeue together
    e = sb.pop_front();
    chk_head("t8_head", e);
    res(0, 39'h6000, 39'h6080, 39'h6080, 0, 0, 1, 0, 64'hC0);
    push(39'h6080, 64'hC0, 1, 0);
    io.attaboy_yumi_i = 1;
    tick(); idle();
    chk("t8_drop", 64'(io.drop_cnt_o), 64'(exp_drop));
    for (int i = 0; i < 4; i++) drain_one($sformatf("t8_drain%0d", i));
    chk("t8_empty", 64'(io.attaboy_v_o), 64'd0);

    // taken-branch mispredict, then reset mid-drain
    res(0, 39'h7000, 39'h7100, 39'h7004, 1, 1, 0, 0, 64'hD0);
    tick(); idle();
    chk_redir("t9_redir", 39'h7100, 1, 1, 0, 0);
    res(1, 39'h7100, 39'h7200, 39'h7200, 0, 0, 1, 0, 64'hD1);
    tick();
    res(1, 39'h7200, 39'h7300, 39'h7204, 0, 1, 0, 0, 64'hD2);
    tick(); idle();
    io.attaboy_yumi_i = io.attaboy_v_o;
    tick();
    #2 reset_n_i = 0;
    #1;
    chk("t9_rst_att_v", 64'(io.attaboy_v_o), 64'd0);
    chk("t9_rst_drop",  64'(io.drop_cnt_o), 64'd0);
    chk("t9_rst_epoch", 64'(io.epoch_o), 64'd0);
    chk("t9_rst_redir", 64'(io.redirect_v_o), 64'd0);
    idle();
    sb.delete();
    exp_drop = 0;
    tick();
    #2 reset_n_i = 1;
    tick();

    // recovery after reset
    res(0, 39'h9000, 39'h9400, 39'h9400, 1, 1, 0, 0, 64'hE0);
    push(39'h9400, 64'hE0, 1, 0);
    tick(); idle();
    drain_one("t10_att");
    chk("t10_drop", 64'(io.drop_cnt_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_cmd_gen.md
Name: bp_be_fe_cmd_gen

Overview:
- Backend-side generator of frontend training and redirect commands; drives the redirect and attaboy inputs of the frontend PC generator.
- Accepts resolved control-flow outcomes from the execute stage and compares each actual next PC against the predicted next PC.
- A mispredict produces a single-cycle redirect. A correct prediction produces an attaboy, which is buffered in a small FIFO and drained with valid/yumi.
- An epoch bit discards wrong-path resolutions issued after a redirect.

Parameters:
- vaddr_width_p, 39, virtual address width
- branch_metadata_fwd_width_p, 64, opaque forwarded branch metadata width
- attaboy_els_p, 4, attaboy FIFO depth (power of 2, >=2)
- drop_cnt_width_p, 8, width of dropped-attaboy counter

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- res_v_i  in  1  resolution valid (always accepted)
- res_epoch_i  in  1  epoch tag of resolving instruction
- res_pc_i  in  vaddr_width_p  PC of resolving instruction
- res_tgt_i  in  vaddr_width_p  computed target
- res_pred_npc_i  in  vaddr_width_p  predicted next PC
- res_taken_i  in  1  branch outcome
- res_is_br_i / res_is_jmp_i / res_nonbr_i  in  1 each  conditional branch / jal-jalr / non-control instruction that had a BTB hit
- res_metadata_i  in  branch_metadata_fwd_width_p  forwarded metadata
- ext_redirect_v_i  in  1  trap/fence redirect
- ext_redirect_pc_i  in  vaddr_width_p  trap target
- redirect_v_o  out  1  redirect pulse
- redirect_pc_o  out  vaddr_width_p  redirect PC
- redirect_br_v_o  out  1  redirect carries branch training
- redirect_br_metadata_fwd_o  out  branch_metadata_fwd_width_p  metadata for the redirect
- redirect_br_taken_o / redirect_br_ntaken_o / redirect_br_nonbr_o  out  1 each
- attaboy_v_o  out  1  FIFO head valid
- attaboy_pc_o  out  vaddr_width_p  head target PC
- attaboy_br_metadata_fwd_o  out  branch_metadata_fwd_width_p  head metadata
- attaboy_taken_o / attaboy_ntaken_o  out  1 each  head outcome
- attaboy_yumi_i  in  1  frontend consumes head
- epoch_o  out  1  current epoch
- drop_cnt_o  out  drop_cnt_width_p  saturating count of attaboys dropped on full

Behaviour:
- Reset: async on reset_n_i low. All outputs 0, epoch_r=0, FIFO empty, drop_cnt=0.
- Accept condition: a resolution is live when res_v_i & (res_epoch_i==epoch_r) & (res_is_br_i|res_is_jmp_i|res_nonbr_i). A mismatched epoch is discarded silently with no side effects.
- actual_npc:
  - res_nonbr_i: res_pc_i+4
  - res_is_jmp_i: res_tgt_i
  - res_is_br_i: res_taken_i ? res_tgt_i : res_pc_i+4
  - Addition is modulo 2^vaddr_width_p.
- Mispredict: live & (res_nonbr_i | actual_npc!=res_pred_npc_i). res_nonbr_i always counts as a mispredict.
- Redirect is registered, so it appears 1 cycle after res_v_i. It lasts exactly 1 cycle and has no backpressure.
  - redirect_pc_o = actual_npc
  - redirect_br_v_o = 1
  - metadata is passed through unchanged
  - taken = (br&res_taken_i)|jmp
  - ntaken = br&~res_taken_i
  - nonbr = res_nonbr_i
  - Exactly one of taken/ntaken/nonbr is 1.
- Each redirect toggles epoch_r in the same edge that registers the redirect. The next resolution carrying the old epoch is discarded.
- External redirect:
  - ext_redirect_v_i registers redirect_v_o=1, redirect_pc_o=ext_redirect_pc_i, redirect_br_v_o=0, taken/ntaken/nonbr=0. Epoch toggles.
  - It has priority over a same-cycle branch redirect or attaboy; that resolution is discarded entirely.
- Attaboy: live & ~mispredict & ~ext_redirect_v_i enqueues {res_tgt_i-or-npc, metadata, taken, ntaken}.
  - pc = actual_npc, taken = (br&res_taken_i)|jmp, ntaken = br&~res_taken_i.
  - Visible on attaboy_v_o the cycle after enqueue. It is never bypassed combinationally.
- FIFO:
  - Circular, attaboy_els_p entries; read/write pointers wrap.
  - Full/empty are distinguished by an extra pointer bit or a count.
  - Dequeue on attaboy_yumi_i. attaboy_yumi_i while empty is illegal and is an assertion.
  - Enqueue and dequeue in the same cycle when full is allowed: the count is unchanged and the entry is accepted.
  - Enqueue when full without a dequeue: the entry is dropped and drop_cnt increments, saturating at all-ones.
- Redirects do not flush the FIFO. Queued attaboys belong to older, correctly resolved instructions and keep draining.
- Attaboy outputs hold stable while attaboy_v_o & ~attaboy_yumi_i.
- Reset asserted mid-operation clears the FIFO, epoch and outputs immediately.

Test Plan:
- Correct taken branch: pc=0x1000, tgt=0x1040, pred=0x1040, epoch 0 -> next cycle attaboy_v_o=1, pc=0x1040, taken=1, ntaken=0; redirect_v_o stays 0; epoch_o stays 0.
- Mispredicted not-taken branch: pc=0x2000, taken=0, pred=0x2080 -> one-cycle redirect_v_o, redirect_pc_o=0x2004, ntaken=1, br_v=1; epoch_o=1. A following resolution with epoch 0 produces nothing.
- False BTB hit: res_nonbr_i=1, pc=0x3000, pred=0x3100 -> redirect_pc_o=0x3004, nonbr=1, taken=ntaken=0.
- Same-cycle ext_redirect_v_i (pc=0x8000_0000) with a mispredicting branch -> single redirect to 0x8000_0000, br_v=0; epoch toggles once.
- attaboy_yumi_i held 0 with 6 correct resolutions, depth 4 -> 4 queued, drop_cnt_o=2. Then yumi each cycle drains 4 entries in FIFO order, and attaboy_v_o falls to 0.
- Full FIFO with simultaneous enqueue+yumi -> count stays 4, drop_cnt unchanged. Then reset_n_i low mid-drain -> attaboy_v_o=0, drop_cnt_o=0, epoch_o=0 asynchronously.
